// File: rtl/mor1kx_dpram_arb.sv
// Access controller for a single-clock true dual-port RAM backing cache arrays.
// Port A serves the pipeline. Port B is shared round-robin between two side
// requesters, with A/B same-address hazard blocking. A bulk-clear sequencer
// uses both ports to write CLEAR_VALUE into every entry.
module mor1kx_dpram_arb #(
  parameter int                    ADDR_WIDTH  = 6,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b0_req,
  input  logic                  b0_we,
  input  logic [ADDR_WIDTH-1:0] b0_addr,
  input  logic [DATA_WIDTH-1:0] b0_wdata,
  input  logic                  b1_req,
  input  logic                  b1_we,
  input  logic [ADDR_WIDTH-1:0] b1_addr,
  input  logic [DATA_WIDTH-1:0] b1_wdata,
  output logic                  b0_gnt,
  output logic                  b1_gnt,
  output logic                  b0_rvalid,
  output logic                  b1_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic                  ram_we_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
);

  // Clear counter walks entry pairs; keep at least one bit for ADDR_WIDTH=1.
  localparam int               CNT_W    = (ADDR_WIDTH > 1) ? ADDR_WIDTH - 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** (ADDR_WIDTH - 1)) - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_last_b1_q;

  logic                  cand_b1;
  logic                  cand_we;
  logic [ADDR_WIDTH-1:0] cand_addr;
  logic [DATA_WIDTH-1:0] cand_wdata;
  logic                  b_any;
  logic                  hazard;
  logic                  b_gnt;
  logic [CNT_W:0]        clr_even;
  logic [CNT_W:0]        clr_odd;

  assign a_rdata = ram_dout_a;
  assign b_rdata = ram_dout_b;

  // Port B candidate selection and A/B hazard detection.
  always_comb begin
    b_any      = b0_req | b1_req;
    cand_b1    = b1_req & (~b0_req | ~rr_last_b1_q);
    cand_we    = cand_b1 ? b1_we    : b0_we;
    cand_addr  = cand_b1 ? b1_addr  : b0_addr;
    cand_wdata = cand_b1 ? b1_wdata : b0_wdata;
    hazard     = a_req & (cand_addr == a_addr) & (a_we | cand_we);
    clr_even   = {cnt_q, 1'b0};
    clr_odd    = {cnt_q, 1'b1};
  end

  // Grants, RAM drive and clear FSM next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    b0_gnt     = 1'b0;
    b1_gnt     = 1'b0;
    ram_addr_a = a_addr;
    ram_din_a  = a_wdata;
    ram_we_a   = 1'b0;
    ram_addr_b = cand_addr;
    ram_din_b  = cand_wdata;
    ram_we_b   = 1'b0;
    case (state_q)
      IDLE: begin
        a_gnt    = a_req;
        b_gnt    = b_any & ~hazard;
        b0_gnt   = b_gnt & ~cand_b1;
        b1_gnt   = b_gnt & cand_b1;
        ram_we_a = a_gnt & a_we;
        ram_we_b = b_gnt & cand_we;
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        ram_addr_a = clr_even[ADDR_WIDTH-1:0];
        ram_din_a  = CLEAR_VALUE;
        ram_we_a   = 1'b1;
        ram_addr_b = clr_odd[ADDR_WIDTH-1:0];
        ram_din_b  = CLEAR_VALUE;
        ram_we_b   = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, round-robin pointer and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_last_b1_q <= 1'b1;
      a_rvalid     <= 1'b0;
      b0_rvalid    <= 1'b0;
      b1_rvalid    <= 1'b0;
      clear_busy   <= 1'b0;
      clear_done   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if (b_gnt) rr_last_b1_q <= cand_b1;
      a_rvalid   <= a_gnt & ~a_we;
      b0_rvalid  <= b0_gnt & ~b0_we;
      b1_rvalid  <= b1_gnt & ~b1_we;
      clear_busy <= (state_d == CLEAR);
      clear_done <= (state_q == CLEAR) && (cnt_q == CNT_LAST);
    end
  end

endmodule

// File: tb/tb_mor1kx_dpram_arb.sv
// Scoreboard bench for mor1kx_dpram_arb with a behavioural RAM and reference model.
module tb_mor1kx_dpram_arb;
  localparam int          AW = 6;
  localparam int          DW = 32;
  localparam int          DEPTH = 64;
  localparam logic [31:0] CV = 32'hA5C3_0F96;

  logic clk = 1'b0, rst_n = 1'b0;
  logic a_req, a_we, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr, b0_addr, b1_addr, ram_addr_a, ram_addr_b;
  logic [DW-1:0] a_wdata, a_rdata, b0_wdata, b1_wdata, b_rdata;
  logic b0_req, b0_we, b1_req, b1_we, b0_gnt, b1_gnt, b0_rvalid, b1_rvalid;
  logic clear_start, clear_busy, clear_done, ram_we_a, ram_we_b;
  logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_a, ram_dout_b;

  mor1kx_dpram_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(CV)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b0_req(b0_req), .b0_we(b0_we), .b0_addr(b0_addr), .b0_wdata(b0_wdata),
    .b1_req(b1_req), .b1_we(b1_we), .b1_addr(b1_addr), .b1_wdata(b1_wdata),
    .b0_gnt(b0_gnt), .b1_gnt(b1_gnt), .b0_rvalid(b0_rvalid), .b1_rvalid(b1_rvalid),
    .b_rdata(b_rdata), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done),
    .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a), .ram_din_a(ram_din_a),
    .ram_dout_a(ram_dout_a),
    .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_din_b(ram_din_b),
    .ram_dout_b(ram_dout_b)
  );

  always #5 clk = ~clk;

  // Behavioural true dual-port RAM, synchronous read.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
    if (ram_we_b) ram[ram_addr_b] <= ram_din_b;
    ram_dout_a <= ram[ram_addr_a];
    ram_dout_b <= ram[ram_addr_b];
  end

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  exp_t qa[$], qb0[$], qb1[$];
  int total = 0, bad = 0, cyc = 0, done_pulses = 0;

  // Reference model state: what the array and arbiter should hold.
  logic [DW-1:0] ref_mem [DEPTH];
  bit m_busy = 0, m_done = 0;
  int m_cnt = 0, m_last = 1;

  task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", n, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference model: predicts grants/status, records expected read data.
  always @(negedge clk) begin : model
    bit ea, eb, sel1, conflict, bwe;
    logic [AW-1:0] baddr;
    logic [DW-1:0] bwd;
    bit nd;
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_cnt = 0; m_last = 1;
      qa.delete(); qb0.delete(); qb1.delete();
    end else begin
      check("clear_busy", clear_busy, m_busy);
      check("clear_done", clear_done, m_done);
      if (clear_done) done_pulses++;
      ea = 0; eb = 0; sel1 = 0;
      if (b0_req && b1_req) sel1 = (m_last == 0);
      else sel1 = b1_req;
      baddr = sel1 ? b1_addr : b0_addr;
      bwe   = sel1 ? b1_we : b0_we;
      bwd   = sel1 ? b1_wdata : b0_wdata;
      if (!m_busy) begin
        ea = a_req;
        conflict = ea && (baddr == a_addr) && (a_we || bwe);
        eb = (b0_req || b1_req) && !conflict;
      end
      check("a_gnt", a_gnt, ea);
      check("b0_gnt", b0_gnt, eb && !sel1);
      check("b1_gnt", b1_gnt, eb && sel1);
      if (ea && !a_we) qa.push_back('{ref_mem[a_addr], cyc + 1});
      if (eb && !bwe) begin
        if (sel1) qb1.push_back('{ref_mem[baddr], cyc + 1});
        else      qb0.push_back('{ref_mem[baddr], cyc + 1});
      end
      if (ea && a_we) ref_mem[a_addr] = a_wdata;
      if (eb && bwe) ref_mem[baddr] = bwd;
      if (eb) m_last = sel1 ? 1 : 0;
      if (m_busy) begin
        ref_mem[2 * m_cnt] = CV;
        ref_mem[2 * m_cnt + 1] = CV;
        nd = (m_cnt == DEPTH / 2 - 1);
        m_cnt++;
        if (nd) m_busy = 0;
        m_done = nd;
      end else begin
        m_done = 0;
        if (clear_start) begin
          m_busy = 1;
          m_cnt = 0;
        end
      end
    end
  end

  // Monitor: pops expected read data whenever the DUT presents rvalid.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (a_rvalid) begin
        if (qa.size() == 0) check("a_rvalid_spurious", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_rdata", a_rdata, e.d);
          check("a_latency", cyc, e.due);
        end
      end else if (qa.size() != 0 && qa[0].due <= cyc) begin
        check("a_rvalid_missing", 0, 1);
        void'(qa.pop_front());
      end
      if (b0_rvalid) begin
        if (qb0.size() == 0) check("b0_rvalid_spurious", 1, 0);
        else begin
          e = qb0.pop_front();
          check("b0_rdata", b_rdata, e.d);
          check("b0_latency", cyc, e.due);
        end
      end else if (qb0.size() != 0 && qb0[0].due <= cyc) begin
        check("b0_rvalid_missing", 0, 1);
        void'(qb0.pop_front());
      end
      if (b1_rvalid) begin
        if (qb1.size() == 0) check("b1_rvalid_spurious", 1, 0);
        else begin
          e = qb1.pop_front();
          check("b1_rdata", b_rdata, e.d);
          check("b1_latency", cyc, e.due);
        end
      end else if (qb1.size() != 0 && qb1[0].due <= cyc) begin
        check("b1_rvalid_missing", 0, 1);
        void'(qb1.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    a_req = 0; a_we = 0; b0_req = 0; b0_we = 0; b1_req = 0; b1_we = 0;
    clear_start = 0;
  endtask

  task automatic a_op(input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    a_req = 1; a_we = we; a_addr = ad; a_wdata = wd;
    step();
    a_req = 0; a_we = 0;
  endtask

  task automatic fill_all();
    for (int unsigned i = 0; i < DEPTH; i++) a_op(1, AW'(i), $urandom | 32'h1);
  endtask

  task automatic read_all();
    for (int unsigned i = 0; i < DEPTH; i++) a_op(0, AW'(i), '0);
    step(); step();
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (clear_busy && n < 200) begin
      n++;
      step();
    end
  endtask

  int n, dp0;

  initial begin
    idle_in();
    a_addr = '0; a_wdata = '0; b0_addr = '0; b0_wdata = '0; b1_addr = '0; b1_wdata = '0;
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();

    // Write then read address 5 on port A.
    a_op(1, 6'd5, 32'hDEADBEEF);
    a_op(0, 6'd5, '0);
    step(); step();
    check("a_readback_5", ref_mem[5], 32'hDEADBEEF);

    fill_all();

    // Both side requesters hold four reads each: round-robin alternation.
    b0_req = 1; b1_req = 1; b0_we = 0; b1_we = 0; b0_addr = 6'd10; b1_addr = 6'd11;
    repeat (4) step();
    idle_in(); step(); step();

    // A write vs b1 read on the same address: blocked, then served next cycle.
    a_req = 1; a_we = 1; a_addr = 6'd9; a_wdata = 32'h1234_5678;
    b1_req = 1; b1_we = 0; b1_addr = 6'd9;
    #1 check("hazard_block", b1_gnt, 0);
    step();
    a_req = 0; a_we = 0;
    #1 check("hazard_release", b1_gnt, 1);
    step();
    // Two reads of the same address are both granted.
    a_req = 1; a_we = 0; a_addr = 6'd9; b1_req = 1; b1_addr = 6'd9;
    #1 check("read_read_both", {a_gnt, b1_gnt}, 2'b11);
    step();
    idle_in(); step(); step();

    // Full clear, then readback of every entry.
    dp0 = done_pulses;
    clear_start = 1; step(); clear_start = 0;
    wait_clear(n);
    check("clear_busy_cycles", n, DEPTH / 2);
    step();
    check("clear_done_pulses", done_pulses - dp0, 1);
    read_all();

    // Requests held during a clear get served in the first idle cycle.
    fill_all();
    clear_start = 1; step(); clear_start = 0;
    a_req = 1; a_we = 0; a_addr = 6'd3; b0_req = 1; b0_we = 0; b0_addr = 6'd4;
    wait_clear(n);
    check("clear_wait_bounded", n < 200, 1);
    check("first_idle_grants", {a_gnt, b0_gnt}, 2'b11);
    step();
    idle_in(); step(); step();

    // Reset in the middle of a clear aborts it.
    fill_all();
    dp0 = done_pulses;
    clear_start = 1; step(); clear_start = 0;
    repeat (10) step();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    step();
    check("abort_busy", clear_busy, 0);
    repeat (40) step();
    check("abort_no_done", done_pulses - dp0, 0);
    read_all();

    // Randomized traffic with narrow addresses to provoke hazards.
    for (int unsigned k = 0; k < 400; k++) begin
      a_req = $urandom_range(0, 1); a_we = $urandom_range(0, 1);
      a_addr = AW'($urandom_range(0, 7)); a_wdata = $urandom;
      b0_req = $urandom_range(0, 1); b0_we = $urandom_range(0, 1);
      b0_addr = AW'($urandom_range(0, 7)); b0_wdata = $urandom;
      b1_req = $urandom_range(0, 1); b1_we = $urandom_range(0, 1);
      b1_addr = AW'($urandom_range(0, 7)); b1_wdata = $urandom;
      clear_start = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_in();
    repeat (40) step();
    read_all();
    check("queues_drained", qa.size() + qb0.size() + qb1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mor1kx_dpram_arb.md
Name: mor1kx_dpram_arb

Overview:
- Access controller for the single-clock true dual-port RAM that backs cache tag/data arrays.
- RAM port A is dedicated to the pipeline requester. RAM port B is shared round-robin between two side requesters (snoop, SPR/config).
- Resolves A/B same-address hazards.
- Provides a bulk-clear sequencer that uses both RAM ports to invalidate the whole array.

Parameters:
ADDR_WIDTH, 6, RAM address width; must be >= 1; depth is 2^ADDR_WIDTH
DATA_WIDTH, 32, RAM word width
CLEAR_VALUE, 0, word written to every entry during a clear (DATA_WIDTH bits)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
a_req / a_we  in  1 / 1  pipeline request; write when a_we=1
a_addr / a_wdata  in  ADDR_WIDTH / DATA_WIDTH  pipeline address and write data
a_gnt  out  1  pipeline request accepted this cycle (combinational)
a_rvalid  out  1  pipeline read data valid
a_rdata  out  DATA_WIDTH  equals ram_dout_a
b0_req, b0_we, b0_addr, b0_wdata  in  1, 1, ADDR_WIDTH, DATA_WIDTH  side requester 0
b1_req, b1_we, b1_addr, b1_wdata  in  1, 1, ADDR_WIDTH, DATA_WIDTH  side requester 1
b0_gnt, b1_gnt  out  1 each  side grants (combinational, one-hot or zero)
b0_rvalid, b1_rvalid  out  1 each  side read data valid
b_rdata  out  DATA_WIDTH  equals ram_dout_b
clear_start  in  1  request a full-array clear
clear_busy  out  1  clear in progress
clear_done  out  1  one-cycle pulse when a clear completes
ram_addr_a, ram_we_a, ram_din_a  out  ADDR_WIDTH, 1, DATA_WIDTH  RAM port A drive
ram_dout_a  in  DATA_WIDTH  RAM port A read data
ram_addr_b, ram_we_b, ram_din_b  out  ADDR_WIDTH, 1, DATA_WIDTH  RAM port B drive
ram_dout_b  in  DATA_WIDTH  RAM port B read data

Behaviour:
- Reset (rst_n low, asynchronous):
  - Registered state: state=IDLE, clear counter=0, round-robin pointer favours b0.
  - Registered outputs: a_rvalid, b0_rvalid, b1_rvalid, clear_busy, clear_done all 0.
  - Reset during CLEAR aborts the clear: array is left partially cleared, no clear_done pulse.
- Grants are combinational and depend only on inputs and registered state. A granted request drives the RAM in the same cycle.
- Port A, state IDLE: a_gnt = a_req. RAM port A fields come from the a_* inputs; ram_we_a = a_gnt & a_we.
- Port B candidate selection, state IDLE:
  - Only one of b0/b1 requests: that one is the candidate.
  - Both request: the candidate is the one not granted most recently.
- Hazard on port B: the candidate is blocked (no grant) when all of the following hold:
  - a_gnt=1;
  - candidate address == a_addr;
  - a_we=1 or candidate_we=1.
  - Two reads of the same address are never blocked.
- When the candidate is blocked, the other B requester is not substituted that cycle.
- Round-robin pointer updates only on an actual B grant.
- ram_we_b = candidate granted & candidate_we.
- When no B grant: ram_we_b=0; ram_addr_b/ram_din_b come from the candidate's fields, or from b0's fields if no B requester.
- Read latency: xx_rvalid rises exactly one cycle after a granted read (we=0); rdata is valid in that cycle. Granted writes produce no rvalid.
- Back-to-back grants are allowed every cycle; throughput is 1 access per port per cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on a clear_start sample; counter <= 0.
  - Requests presented in the same cycle as clear_start are still granted normally.
  - In CLEAR, every cycle:
    - port A writes CLEAR_VALUE to address {cnt,1'b0};
    - port B writes CLEAR_VALUE to address {cnt,1'b1};
    - cnt increments by 1.
  - CLEAR takes 2^(ADDR_WIDTH-1) cycles.
  - On the cycle with cnt == all-ones: state <= IDLE and clear_done <= 1 for exactly one cycle.
  - clear_busy = (state==CLEAR), registered.
  - All gnt are 0 during CLEAR. Requesters hold req and are served in the first IDLE cycle.
  - clear_start is ignored while busy.
  - An rvalid owed from the last IDLE cycle is still delivered in the first CLEAR cycle.

Test Plan:
1. Reset with ADDR_WIDTH=6: a_req=1, a_we=1, a_addr=5, a_wdata=0xDEADBEEF; next cycle read addr 5 -> a_gnt=1 both cycles; a_rvalid=1 one cycle after the read, a_rdata=0xDEADBEEF.
2. b0_req and b1_req held high for 4 reads -> grants alternate b0,b1,b0,b1; the matching rvalid one cycle after each grant; never both gnt high.
3. a_we=1 to addr 9 with b1 read of addr 9 in the same cycle -> b1_gnt=0 that cycle, b1_gnt=1 next cycle, b_rdata = new value. Repeat with a read on A -> both granted.
4. Fill all 64 entries with non-zero data; pulse clear_start -> clear_busy high for exactly 32 cycles, clear_done pulses once; readback of all 64 addresses = CLEAR_VALUE.
5. Assert b0 and a_req during CLEAR -> no grants while busy; both granted in the first cycle after clear_busy falls.
6. Deassert rst_n at clear cycle 10, then release -> clear_busy=0, clear_done never pulses, entries 0..19 = CLEAR_VALUE, entries 20..63 unchanged.
